mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the multicycle CPU.
- Produces the 2*WIDTH-bit product or the quotient/remainder pair into its own Hi/Lo result registers; the datapath reads these as Hi_out/Lo_out through the write-data mux.
- Driven by the control unit with a start/busy/done handshake; the control FSM stalls in a wait state while busy=1.
- Parametrised in operand width; supports signed and unsigned forms of both operations.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, do not override).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous reset, active-low (asserted when 0)
- start  in  1  request; sampled only in IDLE
- op  in  2  00=MULT signed, 01=MULTU, 10=DIV signed, 11=DIVU; sampled with start
- a  in  WIDTH  operand A (multiplicand / dividend); sampled with start
- b  in  WIDTH  operand B (multiplier / divisor); sampled with start
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  single-cycle pulse when hi/lo are updated
- div_zero  out  1  set with done when a DIV/DIVU had b==0; cleared at next acceptance
- hi  out  WIDTH  MULT: upper product half; DIV: remainder
- lo  out  WIDTH  MULT: lower product half; DIV: quotient

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; busy, done and div_zero = 0; hi, lo and all internal registers = 0. Asserting reset mid-operation aborts the operation with no result written.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - With start=1: latch op, a and b; take magnitudes for signed ops; record the result sign (product: sign_a^sign_b; quotient: sign_a^sign_b; remainder: sign_a). Clear div_zero; counter=WIDTH.
  - If the op is DIV/DIVU with b==0, go to DONE directly. Otherwise go to RUN.
- RUN: one iteration per cycle; counter decrements; go to FIX when the counter reaches 1 after that cycle's iteration. RUN lasts exactly WIDTH cycles.
  - Multiply: unsigned shift-add on magnitudes in a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle: shift, trial subtract, keep if non-negative.
- FIX: apply two's-complement negation per the recorded signs (signed ops only); write hi/lo; go to DONE.
- DONE: done=1 for this cycle only; busy=0 in this cycle; return to IDLE.
- Latency:
  - Start accepted at edge E0.
  - Normal ops: hi/lo valid and done=1 during the cycle after edge E(WIDTH+2).
  - Divide by zero: done during the cycle after edge E1.
- Divide-by-zero result: hi=a (unmodified), lo = all ones, div_zero=1.
- Signed division semantics:
  - Quotient truncates toward zero; remainder takes the dividend's sign; the identity a = q*b + r holds.
  - MIN / -1: lo=MIN (wraps), hi=0, no error flag.
- Signed multiply: the full 2*WIDTH signed product; no overflow possible.
- start while busy=1 or in DONE is ignored (no queueing); operands may change freely after acceptance.
- hi/lo hold their value between completions and are never partially updated.

Decomposition:
- Shared CPU package holds:
  - op encodings: MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - the state encoding for IDLE/RUN/FIX/DONE.
- Optional sub-module md_sign_fix: combinational magnitude/negate helper, instantiated for operand conditioning and result correction.
- The FSM, counter and accumulator stay in mult_div_unit.

Test Plan (WIDTH=32):
- MULT a=-3 (0xFFFFFFFD), b=7 -> after 34 cycles done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles before done.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0, div_zero=0; DIVU a=5, b=0 -> done 2 cycles after start, hi=5, lo=0xFFFFFFFF, div_zero=1.
- start pulsed during RUN with new operands -> ignored; result matches the first operands; hi/lo unchanged until done.
- reset driven to 0 mid-RUN (counter=10) -> busy=0, hi=lo=0 immediately (asynchronous); after release, a fresh MULT 6*7 gives lo=42, hi=0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared op and state encodings for the multiply/divide unit
package mult_div_unit_pkg;
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} md_state_t;
endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// md_sign_fix: conditional two's-complement negate, for magnitudes and result correction
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? -x : x;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiplier / restoring divider with Hi/Lo result registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  md_state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc, prod_fix;
  logic [WIDTH-1:0] dvs, a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0] sh, diff, sum;
  logic is_div, neg_q, neg_r, dz_q;
  logic op_div, op_sgn, sa, sb, b_zero, ge;
  assign op_div = op == MD_DIV || op == MD_DIVU;
  assign op_sgn = op == MD_MULT || op == MD_DIV;
  assign sa = op_sgn & a[WIDTH-1];
  assign sb = op_sgn & b[WIDTH-1];
  assign b_zero = b == '0;
  md_sign_fix #(.W(WIDTH)) u_a (.x(a), .neg(sa), .y(a_mag));
  md_sign_fix #(.W(WIDTH)) u_b (.x(b), .neg(sb), .y(b_mag));
  md_sign_fix #(.W(2*WIDTH)) u_p (.x(acc), .neg(neg_q), .y(prod_fix));
  md_sign_fix #(.W(WIDTH)) u_q (.x(acc[WIDTH-1:0]), .neg(neg_q), .y(q_fix));
  md_sign_fix #(.W(WIDTH)) u_r (.x(acc[2*WIDTH-1:WIDTH]), .neg(neg_r), .y(r_fix));
  // Divide step: shifted partial remainder is WIDTH+1 bits so the trial subtract never overflows
  assign sh = acc[2*WIDTH-1:WIDTH-1];
  assign diff = sh - {1'b0, dvs};
  assign ge = sh >= {1'b0, dvs};
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (op_div && b_zero) ? DONE : RUN;
      RUN:  if (cnt == CNT_W'(1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
    endcase
  end
  // acc holds {partial, multiplier} or {remainder, dividend/quotient}; hi/lo copy it only in DONE
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      acc <= '0;
      dvs <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      busy <= state == RUN || state == FIX;
      done <= state == DONE;
      unique case (state)
        IDLE: if (start) begin
          is_div <= op_div;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          dz_q <= op_div && b_zero;
          div_zero <= 1'b0;
          cnt <= CNT_W'(WIDTH);
          dvs <= op_div ? b_mag : a_mag;
          acc <= (op_div && b_zero) ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, op_div ? a_mag : b_mag};
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          acc <= is_div ? {ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0], acc[WIDTH-2:0], ge}
                        : {sum, acc[WIDTH-1:1]};
        end
        FIX: acc <= is_div ? {r_fix, q_fix} : prod_fix;
        DONE: begin
          hi <= acc[2*WIDTH-1:WIDTH];
          lo <= acc[WIDTH-1:0];
          div_zero <= dz_q;
        end
      endcase
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed table of multiply/divide vectors plus ignored-start and async-reset sequences
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, div_zero;
  logic [W-1:0] hi, lo;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;
  vec_t vt[16];
  always #5 clk = ~clk;
  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input int inject);
    logic [31:0] h0, l0;
    int lat, bn;
    logic held;
    @(negedge clk);
    h0 = hi;
    l0 = lo;
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    lat = 0;
    bn = 0;
    held = 1'b1;
    while (lat < 200) begin
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      if (lat == inject) begin
        start = 1'b1;
        op = MD_DIVU;
        a = 32'd100;
        b = 32'd7;
      end
      if (busy) bn++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      lat++;
    end
    start = 1'b0;
    check({tag, " hi"}, 64'(hi), 64'(ehi));
    check({tag, " lo"}, 64'(lo), 64'(elo));
    check({tag, " div_zero"}, 64'(div_zero), 64'(edz));
    check({tag, " latency"}, 64'(lat), edz ? 64'd1 : 64'(W + 2));
    check({tag, " busy cycles"}, 64'(bn), edz ? 64'd0 : 64'(W + 1));
    check({tag, " hi/lo held"}, 64'(held), 64'd1);
    @(negedge clk);
    check({tag, " done pulse"}, 64'(done), 64'd0);
  endtask
  initial begin
    int nd;
    vt[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,       32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vt[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[3]  = '{MD_DIVU,  32'd100,      32'd7,       32'd2,        32'd14,       1'b0};
    vt[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,       32'h80000000, 1'b0};
    vt[5]  = '{MD_DIVU,  32'd5,        32'd0,       32'd5,        32'hFFFFFFFF, 1'b1};
    vt[6]  = '{MD_MULT,  32'd6,        32'd7,       32'd0,        32'd42,       1'b0};
    vt[7]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,       32'hFFFFFFFD, 1'b0};
    vt[8]  = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,       1'b0};
    vt[9]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,       1'b0};
    vt[10] = '{MD_DIV,   32'hFFFFFFF7, 32'd0,       32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1};
    vt[11] = '{MD_MULTU, 32'h12345678, 32'h10,      32'h1,        32'h23456780, 1'b0};
    vt[12] = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,       32'h0,        32'hFFFFFFFF, 1'b0};
    vt[13] = '{MD_DIVU,  32'd3,        32'd10,      32'd3,        32'd0,        1'b0};
    vt[14] = '{MD_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'd0,       32'h1E,       1'b0};
    vt[15] = '{MD_MULT,  32'hFFFFFFFF, 32'd1,       32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++)
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].dz, -1);
    do_op("ignored start", MD_MULT, 32'hFFFFFFFA, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 5);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("ignored start no second done", 64'(nd), 64'd0);
    @(negedge clk);
    op = MD_MULT;
    a = 32'd100;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    repeat (23) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    check("async reset hi", 64'(hi), 64'd0);
    check("async reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    do_op("after reset", MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
